// File: rtl/instr_encoder.sv
// instr_encoder
// Packs decoded LEGv8 fields (op class, registers, signed 64-bit immediate)
// into a 32-bit instruction word. Each word leaves on a valid/ready stream
// together with its byte address, which comes from an internal location
// counter. Inputs whose immediate does not fit the target field, and inputs
// with an unsupported op, are consumed without producing a word and are
// reported on the error outputs.
//
// Ports:
//   Clk, ResetN        clock (rising edge), asynchronous active-low reset
//   InValid/InReady    input field handshake
//   Op, Rd, Rn, Imm    decoded fields (Op: 0 LDUR 1 STUR 2 ADDI 3 CBZ 4 CBNZ 5 B)
//   BaseLoad/BaseAddr  reload the location counter (blocks input that cycle)
//   OutValid/OutReady  output word handshake
//   Instruction        packed 32-bit word
//   OutAddr            byte address of Instruction
//   ErrPulse           one-cycle pulse after a rejected input
//   ErrCode            01 immediate out of range, 10 invalid op (held)
//   ErrCount           saturating count of rejected inputs
`timescale 1ns/1ps

module instr_encoder #(
   parameter int                ADDR_W = 12,
   parameter logic [ADDR_W-1:0] BASE   = '0
) (
   input  logic              Clk,
   input  logic              ResetN,
   input  logic              InValid,
   output logic              InReady,
   input  logic [2:0]        Op,
   input  logic [4:0]        Rd,
   input  logic [4:0]        Rn,
   input  logic [63:0]       Imm,
   input  logic              BaseLoad,
   input  logic [ADDR_W-1:0] BaseAddr,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [31:0]       Instruction,
   output logic [ADDR_W-1:0] OutAddr,
   output logic              ErrPulse,
   output logic [1:0]        ErrCode,
   output logic [7:0]        ErrCount
);

   logic [ADDR_W-1:0] loc_cnt;
   logic              accept;
   logic              out_xfer;
   logic [31:0]       enc_word;
   logic              range_ok;
   logic              op_ok;

   wire fits_9  = (&Imm[63:8])  | ~(|Imm[63:8]);
   wire fits_12 = (&Imm[63:11]) | ~(|Imm[63:11]);
   wire fits_19 = (&Imm[63:18]) | ~(|Imm[63:18]);
   wire fits_26 = (&Imm[63:25]) | ~(|Imm[63:25]);

   assign InReady  = !BaseLoad && (!OutValid || OutReady);
   assign accept   = InValid && InReady;
   assign out_xfer = OutValid && OutReady;

   always_comb begin
      enc_word = 32'd0;
      range_ok = 1'b0;
      op_ok    = 1'b1;
      case (Op)
         3'd0: begin
            enc_word = {11'b11111000010, Imm[8:0], 2'b00, Rn, Rd};
            range_ok = fits_9;
         end
         3'd1: begin
            enc_word = {11'b11111000000, Imm[8:0], 2'b00, Rn, Rd};
            range_ok = fits_9;
         end
         3'd2: begin
            enc_word = {10'b1001000100, Imm[11:0], Rn, Rd};
            range_ok = fits_12;
         end
         3'd3: begin
            enc_word = {8'b10110100, Imm[18:0], Rd};
            range_ok = fits_19;
         end
         3'd4: begin
            enc_word = {8'b10110101, Imm[18:0], Rd};
            range_ok = fits_19;
         end
         3'd5: begin
            enc_word = {6'b000101, Imm[25:0]};
            range_ok = fits_26;
         end
         default: begin
            op_ok = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         OutValid    <= 1'b0;
         Instruction <= 32'd0;
         OutAddr     <= '0;
         ErrPulse    <= 1'b0;
         ErrCode     <= 2'b00;
         ErrCount    <= 8'd0;
         loc_cnt     <= BASE;
      end else begin
         ErrPulse <= 1'b0;
         if (BaseLoad) begin
            loc_cnt <= BaseAddr;
         end
         if (accept && op_ok && range_ok) begin
            OutValid    <= 1'b1;
            Instruction <= enc_word;
            OutAddr     <= loc_cnt;
            loc_cnt     <= loc_cnt + ADDR_W'(4);
         end else begin
            if (out_xfer) begin
               OutValid <= 1'b0;
            end
            if (accept) begin
               ErrPulse <= 1'b1;
               ErrCode  <= op_ok ? 2'b01 : 2'b10;
               if (ErrCount != 8'd255) begin
                  ErrCount <= ErrCount + 8'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed steps followed by a randomized run
// checked against an arithmetic model of the LEGv8 field layouts.
`timescale 1ns/1ps

module tb_instr_encoder;

    localparam int ADDR_W = 12;

    logic              Clk = 1'b0;
    logic              ResetN;
    logic              InValid;
    logic              InReady;
    logic [2:0]        Op;
    logic [4:0]        Rd;
    logic [4:0]        Rn;
    logic [63:0]       Imm;
    logic              BaseLoad;
    logic [ADDR_W-1:0] BaseAddr;
    logic              OutValid;
    logic              OutReady;
    logic [31:0]       Instruction;
    logic [ADDR_W-1:0] OutAddr;
    logic              ErrPulse;
    logic [1:0]        ErrCode;
    logic [7:0]        ErrCount;

    int checks   = 0;
    int failures = 0;

    instr_encoder #(.ADDR_W(ADDR_W), .BASE(12'h000)) dut (
        .Clk(Clk), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
        .Op(Op), .Rd(Rd), .Rn(Rn), .Imm(Imm), .BaseLoad(BaseLoad),
        .BaseAddr(BaseAddr), .OutValid(OutValid), .OutReady(OutReady),
        .Instruction(Instruction), .OutAddr(OutAddr), .ErrPulse(ErrPulse),
        .ErrCode(ErrCode), .ErrCount(ErrCount)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input int op, input int rd, input int rn, input longint imm);
        InValid = 1'b1;
        Op      = 3'(op);
        Rd      = 5'(rd);
        Rn      = 5'(rn);
        Imm     = 64'(imm);
    endtask

    // Reference: field layouts computed as weighted sums, range as a signed
    // interval test. err: 0 ok, 1 immediate out of range, 2 invalid op.
    function automatic void model(input int op, input int rd, input int rn, input longint imm,
                                  output logic [31:0] w, output int err);
        longint v;
        longint lim;
        v   = 0;
        lim = 0;
        err = 0;
        case (op)
            0, 1: begin
                lim = 256;
                v = (op == 0 ? 64'h7C2 : 64'h7C0) * 64'h200000 + (imm & 511) * 4096
                    + longint'(rn) * 32 + longint'(rd);
            end
            2: begin
                lim = 2048;
                v = 64'h244 * 64'h400000 + (imm & 4095) * 1024 + longint'(rn) * 32 + longint'(rd);
            end
            3, 4: begin
                lim = 262144;
                v = (op == 3 ? 64'hB4 : 64'hB5) * 64'h1000000 + (imm & 64'h7FFFF) * 32 + longint'(rd);
            end
            5: begin
                lim = 33554432;
                v = 64'd5 * 64'h4000000 + (imm & 64'h3FFFFFF);
            end
            default: err = 2;
        endcase
        if (err == 0 && (imm < -lim || imm >= lim)) err = 1;
        w = v[31:0];
    endfunction

    function automatic longint pick_imm(input int op);
        longint lim;
        int r;
        case (op)
            0, 1:    lim = 256;
            2:       lim = 2048;
            3, 4:    lim = 262144;
            default: lim = 33554432;
        endcase
        r = $urandom_range(0, 3);
        case (r)
            0:       return longint'($urandom_range(0, 32'(2 * lim - 1))) - lim;
            1:       return ($urandom_range(0, 1) == 1) ? lim - 1 : -lim;
            2:       return ($urandom_range(0, 1) == 1) ? lim : -lim - 1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin : stim
        logic [31:0] ew;
        int          eerr;
        int          cnt;
        int          ecount;
        int          ecode;
        int          op, rd, rn;
        longint      imm;
        logic [31:0] word_a;

        ResetN   = 1'b0;
        InValid  = 1'b0;
        Op       = '0;
        Rd       = '0;
        Rn       = '0;
        Imm      = '0;
        BaseLoad = 1'b0;
        BaseAddr = '0;
        OutReady = 1'b1;
        #12;
        chk("rst_outvalid", 64'(OutValid), 64'd0);
        chk("rst_instr",    64'(Instruction), 64'd0);
        chk("rst_addr",     64'(OutAddr), 64'd0);
        chk("rst_errpulse", 64'(ErrPulse), 64'd0);
        chk("rst_errcode",  64'(ErrCode), 64'd0);
        chk("rst_errcount", 64'(ErrCount), 64'd0);
        chk("rst_inready",  64'(InReady), 64'd1);
        ResetN = 1'b1;
        tick();

        // Directed encodings
        drive(0, 9, 10, -8);
        tick();
        chk("ldur_valid", 64'(OutValid), 64'd1);
        chk("ldur_word",  64'(Instruction), 64'hF85F8149);
        chk("ldur_addr",  64'(OutAddr), 64'h000);
        drive(2, 1, 2, 2047);
        tick();
        chk("addi_word", 64'(Instruction), 64'h911FFC41);
        chk("addi_addr", 64'(OutAddr), 64'h004);
        drive(2, 1, 2, 2048);
        tick();
        chk("addi_oor_valid", 64'(OutValid), 64'd0);
        chk("addi_oor_pulse", 64'(ErrPulse), 64'd1);
        chk("addi_oor_code",  64'(ErrCode), 64'd1);
        chk("addi_oor_count", 64'(ErrCount), 64'd1);
        drive(5, 7, 7, -1);
        tick();
        chk("b_word",  64'(Instruction), 64'h17FFFFFF);
        chk("b_addr",  64'(OutAddr), 64'h008);
        chk("b_pulse", 64'(ErrPulse), 64'd0);
        drive(4, 3, 0, 4);
        tick();
        chk("cbnz_word", 64'(Instruction), 64'hB5000083);
        chk("cbnz_addr", 64'(OutAddr), 64'h00C);
        drive(7, 0, 0, 0);
        tick();
        chk("op7_code",  64'(ErrCode), 64'd2);
        chk("op7_count", 64'(ErrCount), 64'd2);
        chk("op7_valid", 64'(OutValid), 64'd0);
        InValid = 1'b0;
        tick();
        chk("idle_pulse", 64'(ErrPulse), 64'd0);
        chk("idle_code_held", 64'(ErrCode), 64'd2);

        // Backpressure, starting from address 0 via BaseLoad with an offer
        BaseLoad = 1'b1;
        BaseAddr = 12'h000;
        drive(1, 4, 5, 16);
        #1;
        chk("bl_inready", 64'(InReady), 64'd0);
        tick();
        chk("bl_no_accept", 64'(OutValid), 64'd0);
        BaseLoad = 1'b0;
        OutReady = 1'b0;
        model(1, 4, 5, 16, word_a, eerr);
        tick();
        chk("bp_a_valid", 64'(OutValid), 64'd1);
        chk("bp_a_addr",  64'(OutAddr), 64'h000);
        chk("bp_a_word",  64'(Instruction), 64'(word_a));
        drive(3, 6, 0, -100);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_inready", 64'(InReady), 64'd0);
            tick();
            chk("bp_hold_word", 64'(Instruction), 64'(word_a));
            chk("bp_hold_addr", 64'(OutAddr), 64'h000);
            chk("bp_hold_valid", 64'(OutValid), 64'd1);
        end
        OutReady = 1'b1;
        model(3, 6, 0, -100, ew, eerr);
        tick();
        chk("bp_b_word", 64'(Instruction), 64'(ew));
        chk("bp_b_addr", 64'(OutAddr), 64'h004);
        InValid = 1'b0;
        tick();
        chk("bp_drained", 64'(OutValid), 64'd0);

        // Counter wrap
        BaseLoad = 1'b1;
        BaseAddr = 12'hFFC;
        drive(2, 1, 1, 1);
        tick();
        chk("wrap_bl_no_accept", 64'(OutValid), 64'd0);
        BaseLoad = 1'b0;
        tick();
        chk("wrap_addr0", 64'(OutAddr), 64'hFFC);
        tick();
        chk("wrap_addr1", 64'(OutAddr), 64'h000);
        InValid = 1'b0;
        tick();

        // Reset while a word is stalled
        OutReady = 1'b0;
        drive(0, 1, 1, 1);
        tick();
        chk("stall_valid", 64'(OutValid), 64'd1);
        InValid = 1'b0;
        #2;
        ResetN = 1'b0;
        #1;
        chk("midrst_valid", 64'(OutValid), 64'd0);
        chk("midrst_instr", 64'(Instruction), 64'd0);
        chk("midrst_addr",  64'(OutAddr), 64'd0);
        chk("midrst_count", 64'(ErrCount), 64'd0);
        chk("midrst_code",  64'(ErrCode), 64'd0);
        #3;
        ResetN   = 1'b1;
        OutReady = 1'b1;
        tick();
        drive(5, 0, 0, 40);
        tick();
        chk("post_rst_addr", 64'(OutAddr), 64'h000);
        chk("post_rst_word", 64'(Instruction), 64'h1400_0028);

        // Randomized run against the model
        cnt    = 4;
        ecount = 0;
        ecode  = 0;
        for (int i = 0; i < 300; i++) begin
            op  = int'($urandom_range(0, 7));
            rd  = int'($urandom_range(0, 31));
            rn  = int'($urandom_range(0, 31));
            imm = pick_imm(op);
            if ($urandom_range(0, 4) == 0) begin
                InValid = 1'b0;
                Op = 3'(op);
                tick();
                chk("rnd_idle_valid", 64'(OutValid), 64'd0);
                chk("rnd_idle_pulse", 64'(ErrPulse), 64'd0);
            end else begin
                drive(op, rd, rn, imm);
                model(op, rd, rn, imm, ew, eerr);
                tick();
                if (eerr == 0) begin
                    chk("rnd_valid", 64'(OutValid), 64'd1);
                    chk("rnd_word",  64'(Instruction), 64'(ew));
                    chk("rnd_addr",  64'(OutAddr), 64'(cnt % 4096));
                    chk("rnd_pulse", 64'(ErrPulse), 64'd0);
                    cnt = (cnt + 4) % 4096;
                end else begin
                    ecode  = eerr;
                    ecount = (ecount < 255) ? ecount + 1 : 255;
                    chk("rnd_err_valid", 64'(OutValid), 64'd0);
                    chk("rnd_err_pulse", 64'(ErrPulse), 64'd1);
                end
            end
            chk("rnd_code",  64'(ErrCode), 64'(ecode));
            chk("rnd_count", 64'(ErrCount), 64'(ecount));
        end
        InValid = 1'b0;
        tick();

        // Saturation
        for (int i = 0; i < 300; i++) begin
            drive(6, 0, 0, 0);
            tick();
            ecount = (ecount < 255) ? ecount + 1 : 255;
        end
        chk("sat_count", 64'(ErrCount), 64'd255);
        chk("sat_count_model", 64'(ErrCount), 64'(ecount));
        chk("sat_pulse", 64'(ErrPulse), 64'd1);
        chk("sat_code",  64'(ErrCode), 64'd2);
        drive(6, 0, 0, 0);
        tick();
        chk("sat_hold", 64'(ErrCount), 64'd255);
        InValid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the datapath's immediate sign-extender: packs decoded fields (op class, registers, signed 64-bit immediate) into a 32-bit LEGv8 instruction word.
- Checks that the immediate fits its field; out-of-range or unsupported ops are rejected.
- Emits each packed word with a byte address from an internal location counter over a valid/ready stream.
- Feeds the instruction-memory loader and the bench program builder.

Parameters:
- ADDR_W, 12, width of byte-address counter (wraps modulo 2^ADDR_W)
- BASE, 0, reset value of address counter

Ports:
- Clk  in  1  clock, rising edge
- ResetN  in  1  asynchronous active-low reset
- InValid  in  1  input fields valid
- InReady  out  1  encoder can accept
- Op  in  3  0 LDUR, 1 STUR, 2 ADDI, 3 CBZ, 4 CBNZ, 5 B, 6-7 invalid
- Rd  in  5  Rt (LDUR/STUR/CBZ/CBNZ) or Rd (ADDI); ignored for B
- Rn  in  5  base/source register; ignored for CBZ/CBNZ/B
- Imm  in  64  signed immediate (two's complement)
- BaseLoad  in  1  load address counter from BaseAddr
- BaseAddr  in  ADDR_W  new counter value
- OutValid  out  1  packed word valid
- OutReady  in  1  consumer accepts
- Instruction  out  32  packed word
- OutAddr  out  ADDR_W  byte address of Instruction
- ErrPulse  out  1  one-cycle pulse on rejected input
- ErrCode  out  2  01 immediate out of range, 10 invalid Op; held until next error
- ErrCount  out  8  rejected-input count, saturates at 255

Behaviour:
- Reset (async, ResetN=0):
  - OutValid=0, Instruction=0, OutAddr=0, ErrPulse=0, ErrCode=0, ErrCount=0.
  - Counter=BASE.
  - Applies immediately mid-transfer; a pending word is discarded.
- Handshake:
  - InReady = !BaseLoad && (!OutValid || OutReady), combinational.
  - Input accepted on a rising edge with InValid && InReady.
  - Output transfer occurs on a rising edge with OutValid && OutReady.
  - While OutValid=1 && OutReady=0, Instruction and OutAddr hold stable.
- Latency: accepted valid input → OutValid=1 the next cycle. Throughput is one word/cycle when OutReady is held high.
- Field packing, immediate = low bits of Imm:
  - LDUR: 11111000010, Imm[8:0] at [20:12], 00 at [11:10], Rn at [9:5], Rt at [4:0].
  - STUR: same as LDUR with opcode 11111000000.
  - ADDI: 1001000100 at [31:22], Imm[11:0] at [21:10], Rn, Rd.
  - CBZ: 10110100 at [31:24], Imm[18:0] at [23:5], Rt. CBNZ uses opcode 10110101.
  - B: 000101 at [31:26], Imm[25:0].
- Range check: Imm must equal the sign-extension of its field width.
  - LDUR/STUR: 9 bits, -256..255.
  - ADDI: 12 bits, -2048..2047.
  - CBZ/CBNZ: 19 bits.
  - B: 26 bits.
- Rejected input (range error or Op 6/7):
  - Input is still consumed, but no word is produced.
  - OutValid is not set and the counter does not advance.
  - Next cycle: ErrPulse=1, ErrCode updated, ErrCount += 1 (saturating).
  - An in-flight OutValid word is unaffected.
- Address counter:
  - On each accepted valid input, OutAddr ← counter, then counter += 4.
  - Wraps modulo 2^ADDR_W.
- BaseLoad:
  - Counter ← BaseAddr at the edge.
  - Blocks acceptance that cycle.
  - Does not disturb a pending output word.
- Simultaneous output transfer and new accept: the output register is replaced with the new word and OutValid stays 1.

Test Plan:
- LDUR Rt=9, Rn=10, Imm=-8 → Instruction=0xF85F8149, OutAddr=0x000; next OutAddr=0x004.
- ADDI Rd=1, Rn=2, Imm=2047 → 0x911FFC41. Then Imm=2048 → no word, ErrPulse, ErrCode=01, ErrCount=1, next OutAddr unchanged.
- B Imm=-1 → 0x17FFFFFF. CBNZ Rt=3, Imm=4 → 0xB5000083. Op=7 → ErrCode=10.
- Backpressure: hold OutReady=0 for 3 cycles with InValid=1 → InReady=0 and the first word is held stable. Release → words at 0x000 then 0x004, none lost or duplicated.
- BaseLoad BaseAddr=0xFFC (ADDR_W=12), then two inputs → OutAddr 0xFFC then 0x000. Any input offered during the BaseLoad cycle is not accepted.
- Assert ResetN=0 mid-stall with OutValid=1 → outputs clear immediately; after release, first word is at BASE. Drive 300 errors → ErrCount stays at 255.
